tim_ctrl: RTL and testbench
===========================

Name: tim_ctrl

Overview:
Timer controller for the peripheral subsystem. It owns a programmable prescaler and an auto-reload up-counter, and exposes both through a small register interface. It generates a one-cycle prescaled tick enable, a counter-update pulse and a level interrupt. All logic runs on one clock with enables, and no divided clock is produced. Downstream peripherals consume `tick_o`/`upd_o` as clock enables.

Parameters:
- CNT_W, 32, width of the counter, PSC and ARR registers (1..32).
- RST_ARR, 32'hFFFF_FFFF, reset value of ARR (truncated to CNT_W).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- we  in  1  register write strobe
- re  in  1  register read strobe
- addr  in  5  byte address; bits [1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, registered
- ready  out  1  access acknowledge, one cycle after we/re
- tick_o  out  1  prescaled enable pulse, one cycle wide
- upd_o  out  1  update-event pulse, one cycle wide
- irq  out  1  interrupt level

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - All state updates on posedge clk.
  - While rst=1, every register takes its reset value on each edge.
- Register map:
  - 0x00 CTRL, reset 0: bit0 EN, bit1 OPM (one-shot), bit2 IE. Other bits read 0.
  - 0x04 PSC, reset 0: preload. Division ratio = PSC+1.
  - 0x08 ARR, reset RST_ARR: preload.
  - 0x0C CNT, reset 0: read returns the live counter. A write loads the counter and clears the prescaler counter.
  - 0x10 SR, reset 0: bit0 UIF. Write-1-to-clear; writing 0 has no effect.
  - Unmapped addresses read 0; writes to them are ignored.
- Shadow registers:
  - PSC_act and ARR_act are used by the datapath.
  - Preload is copied into them on every update event, and on an EN 0->1 write.
  - PSC/ARR writes never affect the running period directly.
- Bus timing:
  - rdata and ready are registered; ready=1 on the cycle after we|re.
  - rdata holds its value until the next read.
  - If we and re are both asserted, the write is performed and rdata returns the pre-write value.
- Prescaler:
  - When EN=1, psc_cnt increments each cycle.
  - When psc_cnt==PSC_act, psc_cnt wraps to 0 and tick_o=1 on the following cycle (registered).
  - PSC_act=0 gives tick_o high every cycle.
  - When EN=0, psc_cnt holds and tick_o=0.
- Counter:
  - On an internal tick with CNT!=ARR_act: CNT increments.
  - On an internal tick with CNT==ARR_act: CNT<=0, upd_o=1 (registered, aligned with tick_o), UIF<=1, shadows reload.
  - If OPM=1 at that event, EN<=0.
  - ARR_act=0: CNT stays 0 and every tick is an update.
- Counter write while running: CNT write takes priority over the tick increment in the same cycle, and psc_cnt<=0.
- EN cleared by software: counter and psc_cnt freeze; resume on the next EN set, after the shadow reload.
- UIF collision: a hardware set and a W1C in the same cycle leave UIF=1 (set wins).
- irq = UIF & IE, built only from flops, with no glitch path from bus inputs.
- Reset outputs: rdata=0, ready=0, tick_o=0, upd_o=0, irq=0.
- Reset mid-count: everything returns to reset values on the next edge, with no pending pulses.

Decomposition:
- Package tim_pkg:
  - register offset localparams (TIM_CTRL, TIM_PSC, TIM_ARR, TIM_CNT, TIM_SR)
  - CTRL bit-index constants
  - packed struct tim_ctrl_t {ie, opm, en}
- Sub-module tim_psc: prescaler counter with enable, synchronous clear and load of PSC_act; outputs a registered tick.
- Everything else (bus decode, CNT, SR, shadows) lives in tim_ctrl.

Test Plan:
- Reset defaults: after rst, reads return CTRL=0, PSC=0, ARR=32'hFFFF_FFFF, CNT=0, SR=0; irq=0, tick_o=0.
- Periodic update: PSC=3, ARR=4, CTRL=0x5.
  - tick_o every 4 cycles.
  - upd_o every 20 cycles.
  - irq rises on the first update and stays high until SR is written with 1.
- Preload behaviour: while running with ARR=4, write ARR=9.
  - The current period still ends at CNT=4.
  - The next period ends at CNT=9.
- One-shot: PSC=0, ARR=2, CTRL=0x3.
  - Exactly one upd_o after 3 ticks.
  - CTRL reads 0x2 afterwards.
  - CNT reads 0 and holds.
- Collisions:
  - A W1C to SR in the same cycle as the hardware UIF set leaves SR=1.
  - A CNT write of 7 in the same cycle as a tick reads back 7, and psc_cnt restarts.
- Reset mid-operation: assert rst for 1 cycle during counting.
  - All outputs are 0 on the next cycle.
  - EN=0; no tick_o/upd_o until reprogrammed.

Source files
------------

// File: rtl/tim_pkg.sv
// Shared constants and types for the timer controller.
package tim_pkg;

  localparam logic [4:0] TIM_CTRL = 5'h00;
  localparam logic [4:0] TIM_PSC  = 5'h04;
  localparam logic [4:0] TIM_ARR  = 5'h08;
  localparam logic [4:0] TIM_CNT  = 5'h0C;
  localparam logic [4:0] TIM_SR   = 5'h10;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_OPM = 1;
  localparam int unsigned CTRL_IE  = 2;
  localparam int unsigned CTRL_W   = 3;

  typedef struct packed {
    logic ie;
    logic opm;
    logic en;
  } tim_ctrl_t;

endpackage

// File: rtl/tim_psc.sv
// Prescaler: counts enabled cycles up to the active PSC value and emits a tick.
// o_tick_c is the same-cycle wrap condition; o_tick is its registered copy.
module tim_psc #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_psc,
  output logic             o_tick_c,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_psc_act;
  logic [CNT_W-1:0] r_psc_cnt;
  logic             r_tick;

  assign o_tick_c = i_en & (r_psc_cnt == r_psc_act);
  assign o_tick   = r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psc_act <= '0;
      r_psc_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      if (i_load) r_psc_act <= i_psc;
      // A counter write restarts the prescaler phase.
      if (i_clr)         r_psc_cnt <= '0;
      else if (o_tick_c) r_psc_cnt <= '0;
      else if (i_en)     r_psc_cnt <= r_psc_cnt + CNT_W'(1);
      r_tick <= o_tick_c;
    end
  end

endmodule

// File: rtl/tim_ctrl.sv
// Timer controller: register interface, auto-reload counter, status and interrupt.
// PSC/ARR are preloads; the datapath uses shadow copies refreshed on update or EN rise.
module tim_ctrl
  import tim_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] RST_ARR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tick_o,
  output logic        upd_o,
  output logic        irq
);

  tim_ctrl_t        r_ctrl;
  logic [CNT_W-1:0] r_psc_pre;
  logic [CNT_W-1:0] r_arr_pre;
  logic [CNT_W-1:0] r_arr_act;
  logic [CNT_W-1:0] r_cnt;
  logic             r_uif;
  logic             r_irq;
  logic             r_upd;
  logic             r_ready;
  logic [31:0]      r_rdata;

  logic [4:0]       w_addr;
  logic             w_wr_ctrl, w_wr_psc, w_wr_arr, w_wr_cnt, w_wr_sr;
  logic             w_en_rise, w_tick, w_upd, w_reload;
  tim_ctrl_t        w_ctrl_nxt;
  logic             w_uif_nxt;
  logic [31:0]      w_rdata;

  assign w_addr    = addr & 5'b11100;
  assign w_wr_ctrl = we & (w_addr == TIM_CTRL);
  assign w_wr_psc  = we & (w_addr == TIM_PSC);
  assign w_wr_arr  = we & (w_addr == TIM_ARR);
  assign w_wr_cnt  = we & (w_addr == TIM_CNT);
  assign w_wr_sr   = we & (w_addr == TIM_SR);

  assign w_en_rise = w_wr_ctrl & wdata[CTRL_EN] & ~r_ctrl.en;
  // A software counter load pre-empts the update in the same cycle.
  assign w_upd     = w_tick & ~w_wr_cnt & (r_cnt == r_arr_act);
  assign w_reload  = w_upd | w_en_rise;

  tim_psc #(.CNT_W(CNT_W)) u_psc (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_ctrl.en),
    .i_clr    (w_wr_cnt),
    .i_load   (w_reload),
    .i_psc    (r_psc_pre),
    .o_tick_c (w_tick),
    .o_tick   (tick_o)
  );

  // Next CTRL/UIF; hardware UIF set beats a simultaneous W1C.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    w_uif_nxt  = r_uif;
    if (w_wr_ctrl)                w_ctrl_nxt = tim_ctrl_t'(wdata[CTRL_W-1:0]);
    else if (w_upd && r_ctrl.opm) w_ctrl_nxt.en = 1'b0;
    if (w_upd)                    w_uif_nxt = 1'b1;
    else if (w_wr_sr && wdata[0]) w_uif_nxt = 1'b0;
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      TIM_CTRL: w_rdata = {29'd0, r_ctrl};
      TIM_PSC:  w_rdata = 32'(r_psc_pre);
      TIM_ARR:  w_rdata = 32'(r_arr_pre);
      TIM_CNT:  w_rdata = 32'(r_cnt);
      TIM_SR:   w_rdata = {31'd0, r_uif};
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_psc_pre <= '0;
      r_arr_pre <= CNT_W'(RST_ARR);
      r_arr_act <= CNT_W'(RST_ARR);
      r_cnt     <= '0;
      r_uif     <= 1'b0;
      r_irq     <= 1'b0;
      r_upd     <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      r_uif  <= w_uif_nxt;
      r_irq  <= w_uif_nxt & w_ctrl_nxt.ie;
      if (w_wr_psc) r_psc_pre <= CNT_W'(wdata);
      if (w_wr_arr) r_arr_pre <= CNT_W'(wdata);
      if (w_reload) r_arr_act <= r_arr_pre;
      if (w_wr_cnt)    r_cnt <= CNT_W'(wdata);
      else if (w_upd)  r_cnt <= '0;
      else if (w_tick) r_cnt <= r_cnt + CNT_W'(1);
      r_upd   <= w_upd;
      r_ready <= we | re;
      if (re) r_rdata <= w_rdata;
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign upd_o = r_upd;
  assign irq   = r_irq;

endmodule

// File: tb/tb_tim_ctrl.sv
// Directed bench for tim_ctrl: register table plus multi-cycle timing sequences.
module tb_tim_ctrl;
  import tim_pkg::*;

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready, tick_o, upd_o, irq;

  int n_tests = 0;
  int n_fail  = 0;

  tim_ctrl #(.CNT_W(32), .RST_ARR(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .tick_o(tick_o), .upd_o(upd_o), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All bus tasks start and end just after a negedge; each takes one cycle.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    check("wr_ready", 32'(ready), 32'd1);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0;
    d = rdata;
    check("rd_ready", 32'(ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n_upd;

    vecs[0]  = '{1'b0, TIM_CTRL, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, TIM_PSC,  32'h0, 32'h0};
    vecs[2]  = '{1'b0, TIM_ARR,  32'h0, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, TIM_CNT,  32'h0, 32'h0};
    vecs[4]  = '{1'b0, TIM_SR,   32'h0, 32'h0};
    vecs[5]  = '{1'b0, 5'h14,    32'h0, 32'h0};
    vecs[6]  = '{1'b1, TIM_PSC,  32'h3, 32'h0};
    vecs[7]  = '{1'b0, TIM_PSC,  32'h0, 32'h3};
    vecs[8]  = '{1'b1, TIM_ARR,  32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b0, TIM_ARR,  32'h0, 32'h1234_5678};
    vecs[10] = '{1'b1, TIM_CTRL, 32'hFFFF_FFF6, 32'h0};
    vecs[11] = '{1'b0, TIM_CTRL, 32'h0, 32'h6};
    vecs[12] = '{1'b1, 5'h18,    32'hDEAD_BEEF, 32'h0};
    vecs[13] = '{1'b0, 5'h18,    32'h0, 32'h0};
    vecs[14] = '{1'b0, 5'h05,    32'h0, 32'h3};
    vecs[15] = '{1'b1, TIM_SR,   32'h1, 32'h0};
    vecs[16] = '{1'b0, TIM_SR,   32'h0, 32'h0};
    vecs[17] = '{1'b1, TIM_CTRL, 32'h0, 32'h0};
    vecs[18] = '{1'b0, TIM_CNT,  32'h0, 32'h0};

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_tick",  32'(tick_o), 32'd0);
    check("rst_upd",   32'(upd_o),  32'd0);
    check("rst_irq",   32'(irq),    32'd0);
    check("rst_ready", 32'(ready),  32'd0);
    check("rst_rdata", rdata,       32'd0);

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].is_wr) wr(vecs[k].addr, vecs[k].data);
      else begin
        rd(vecs[k].addr, d);
        check($sformatf("vec%0d_rd", k), d, vecs[k].exp);
      end
    end

    // Simultaneous write and read returns the pre-write value; rdata then holds.
    we = 1'b1; re = 1'b1; addr = TIM_PSC; wdata = 32'h5;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    check("wr_rd_old", rdata, 32'h3);
    rd(TIM_PSC, d);
    check("wr_rd_new", d, 32'h5);
    @(negedge clk);
    check("rdata_hold", rdata, 32'h5);
    check("ready_idle", 32'(ready), 32'd0);

    // Periodic: tick every 4 cycles, update every 20.
    do_reset();
    wr(TIM_PSC, 32'd3); wr(TIM_ARR, 32'd4); wr(TIM_CTRL, 32'h5);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check($sformatf("per_tick_c%0d", i), 32'(tick_o), 32'(i % 4 == 0));
      check($sformatf("per_upd_c%0d", i),  32'(upd_o),  32'(i % 20 == 0));
      check($sformatf("per_irq_c%0d", i),  32'(irq),    32'(i >= 20));
    end
    wr(TIM_SR, 32'h1);
    check("per_irq_clr", 32'(irq), 32'd0);
    rd(TIM_SR, d);
    check("per_sr_clr", d, 32'd0);

    // Preload: ARR change lands only after the current period.
    do_reset();
    wr(TIM_PSC, 32'd0); wr(TIM_ARR, 32'd4); wr(TIM_CTRL, 32'h1);
    wr(TIM_ARR, 32'd9);
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("pre_upd_c%0d", i),  32'(upd_o),  32'(i == 5 || i == 15));
      check($sformatf("pre_tick_c%0d", i), 32'(tick_o), 32'd1);
    end

    // One-shot: single update after three ticks, then stopped.
    do_reset();
    wr(TIM_ARR, 32'd2); wr(TIM_CTRL, 32'h3);
    n_upd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (upd_o) n_upd++;
      check($sformatf("opm_upd_c%0d", i),  32'(upd_o),  32'(i == 3));
      check($sformatf("opm_tick_c%0d", i), 32'(tick_o), 32'(i <= 3));
    end
    check("opm_upd_count", 32'(n_upd), 32'd1);
    rd(TIM_CTRL, d);
    check("opm_ctrl", d, 32'h2);
    rd(TIM_CNT, d);
    check("opm_cnt0", d, 32'd0);
    repeat (5) @(negedge clk);
    rd(TIM_CNT, d);
    check("opm_cnt_hold", d, 32'd0);

    // UIF collision: W1C in the same cycle as the hardware set.
    do_reset();
    wr(TIM_ARR, 32'd2); wr(TIM_CTRL, 32'h5);
    repeat (5) @(negedge clk);
    check("col_irq_pre", 32'(irq), 32'd1);
    wr(TIM_SR, 32'h1);
    check("col_upd_same", 32'(upd_o), 32'd1);
    check("col_irq_kept", 32'(irq), 32'd1);
    rd(TIM_SR, d);
    check("col_sr", d, 32'd1);
    wr(TIM_SR, 32'h1);
    check("col_irq_clr", 32'(irq), 32'd0);

    // CNT write on a tick, then mid-period to show the prescaler restart.
    do_reset();
    wr(TIM_PSC, 32'd2); wr(TIM_ARR, 32'd20); wr(TIM_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    wr(TIM_CNT, 32'd7);
    check("cw_tick_same", 32'(tick_o), 32'd1);
    rd(TIM_CNT, d);
    check("cw_cnt7", d, 32'd7);
    @(negedge clk);
    check("cw_tick_n5", 32'(tick_o), 32'd0);
    @(negedge clk);
    check("cw_tick_n6", 32'(tick_o), 32'd1);
    rd(TIM_CNT, d);
    check("cw_cnt8", d, 32'd8);
    wr(TIM_CNT, 32'd3);
    @(negedge clk);
    check("cw_tick_n9", 32'(tick_o), 32'd0);
    @(negedge clk);
    check("cw_tick_n10", 32'(tick_o), 32'd0);
    @(negedge clk);
    check("cw_tick_n11", 32'(tick_o), 32'd1);
    rd(TIM_CNT, d);
    check("cw_cnt4", d, 32'd4);

    // Reset mid-count clears pending pulses and stops the timer.
    do_reset();
    wr(TIM_ARR, 32'd3); wr(TIM_CTRL, 32'h5);
    rd(TIM_ARR, d);
    check("mr_arr", d, 32'd3);
    repeat (3) @(negedge clk);
    check("mr_upd_pre", 32'(upd_o), 32'd1);
    check("mr_irq_pre", 32'(irq), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_tick",  32'(tick_o), 32'd0);
    check("mr_upd",   32'(upd_o),  32'd0);
    check("mr_irq",   32'(irq),    32'd0);
    check("mr_ready", 32'(ready),  32'd0);
    check("mr_rdata", rdata,       32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("mr_idle_tick%0d", i), 32'(tick_o), 32'd0);
      check($sformatf("mr_idle_upd%0d", i),  32'(upd_o),  32'd0);
    end
    rd(TIM_CTRL, d);
    check("mr_ctrl", d, 32'd0);
    rd(TIM_CNT, d);
    check("mr_cnt", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
